// File: rtl/s2_route_demux_if.sv
// rtl/s2_route_demux_if.sv - handshake bundle for the S2-decoded 1-to-4 route demux
// Upstream word/select/valid/ready plus the four registered output lanes.
interface s2_route_demux_if #(
  parameter int N = 1
);
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         A1;
  logic         B1;
  logic         A0;
  logic         B0;
  logic [N-1:0] out0;
  logic [N-1:0] out1;
  logic [N-1:0] out2;
  logic [N-1:0] out3;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;

  modport master (
    output in_data, in_valid, A1, B1, A0, B0, out_ready,
    input  in_ready, out0, out1, out2, out3, out_valid
  );

  modport slave (
    input  in_data, in_valid, A1, B1, A0, B0, out_ready,
    output in_ready, out0, out1, out2, out3, out_valid
  );
endinterface

// File: rtl/s2_route_demux.sv
// rtl/s2_route_demux.sv - registered 1-to-4 demux using the S2 select decode
// Each lane is a one-entry register with its own valid/ready handshake.
module s2_route_demux #(
  parameter int N = 1
) (
  input  logic             clk,
  input  logic             clr,
  s2_route_demux_if.slave  bus
);

  logic [1:0]   w_sel;
  logic         w_in_ready;
  logic         w_accept;
  logic [N-1:0] r_lane [4];
  logic [3:0]   r_valid;

  // S1 is an OR of its terms, S0 an AND, matching the S2 mux cell.
  assign w_sel      = {bus.A1 | bus.B1, bus.A0 & bus.B0};
  assign w_in_ready = ~r_valid[w_sel] | bus.out_ready[w_sel];
  assign w_accept   = bus.in_valid & w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out0      = r_lane[0];
  assign bus.out1      = r_lane[1];
  assign bus.out2      = r_lane[2];
  assign bus.out3      = r_lane[3];
  assign bus.out_valid = r_valid;

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 4; k++) begin
        r_lane[k] <= '0;
      end
      r_valid <= 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        // Fill wins over consume so a simultaneous pop/push keeps the lane full.
        if (w_accept && (w_sel == 2'(k))) begin
          r_lane[k]  <= bus.in_data;
          r_valid[k] <= 1'b1;
        end else if (r_valid[k] && bus.out_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_s2_route_demux.sv
// tb/tb_s2_route_demux.sv - self-checking bench for s2_route_demux
// Lanes are modelled as depth-1 queues plus the last word written to each lane.
module tb_s2_route_demux;
  localparam int N = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [N-1:0] lane_q [4][$];
  logic [N-1:0] exp_out [4];

  s2_route_demux_if #(.N(N)) bus();

  s2_route_demux #(.N(N)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int model_sel();
    int s1 = (bus.A1 || bus.B1) ? 1 : 0;
    int s0 = (bus.A0 && bus.B0) ? 1 : 0;
    return s1 * 2 + s0;
  endfunction

  function automatic logic model_ready();
    int s = model_sel();
    return (lane_q[s].size() == 0) || bus.out_ready[s];
  endfunction

  function automatic logic [3:0] model_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = (lane_q[k].size() != 0);
    return v;
  endfunction

  function automatic logic [N-1:0] dut_out(int k);
    case (k)
      0: return bus.out0;
      1: return bus.out1;
      2: return bus.out2;
      default: return bus.out3;
    endcase
  endfunction

  task automatic model_step();
    int   s   = model_sel();
    logic rdy = model_ready();
    if (clr) begin
      for (int k = 0; k < 4; k++) begin
        lane_q[k].delete();
        exp_out[k] = '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (lane_q[k].size() != 0 && bus.out_ready[k]) void'(lane_q[k].pop_front());
        if (bus.in_valid && rdy && s == k) begin
          lane_q[k].push_back(bus.in_data);
          exp_out[k] = bus.in_data;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [N-1:0] d, logic a1, logic b1, logic a0, logic b0, logic [3:0] rdy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.A1        = a1;
    bus.B1        = b1;
    bus.A0        = a0;
    bus.B0        = b0;
    bus.out_ready = rdy;
    #1;
  endtask

  task automatic drive_sel(int s);
    logic [1:0] t;
    if (s >= 2) begin
      t = 2'($urandom_range(1, 3));
      bus.A1 = t[1]; bus.B1 = t[0];
    end else begin
      bus.A1 = 1'b0; bus.B1 = 1'b0;
    end
    if (s % 2 == 1) begin
      bus.A0 = 1'b1; bus.B0 = 1'b1;
    end else begin
      t = 2'($urandom_range(0, 2));
      bus.A0 = t[1]; bus.B0 = t[0];
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (bus.out_valid !== 4'b0000) begin
        errors++;
        $display("FAIL reset_valid cycle %0d got %b want 0000", c, bus.out_valid);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dut_out(k) !== '0) begin
          errors++;
          $display("FAIL reset_out%0d got %h want 0", k, dut_out(k));
        end
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_fill_stall();
    drive(1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fill_ready got %b want 1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out1 !== 4'hA || bus.out_valid !== 4'b0010) begin
      errors++;
      $display("FAIL fill_lane1 got out1=%h valid=%b want A 0010", bus.out1, bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready got %b want 0", bus.in_ready);
    end
  endtask

  task automatic test_independence();
    drive(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL indep_ready got %b want 1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out2 !== 4'h3 || bus.out_valid !== 4'b0110 || bus.out1 !== 4'hA) begin
      errors++;
      $display("FAIL indep_lanes got out2=%h valid=%b out1=%h want 3 0110 A", bus.out2, bus.out_valid, bus.out1);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] words [4] = '{4'h7, 4'h8, 4'h9, 4'hB};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, words[i], 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready word %0d got %b want 1", i, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out2 !== words[i] || bus.out_valid[2] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_out2 word %0d got %h/%b want %h/1", i, bus.out2, bus.out_valid[2], words[i]);
      end
    end
  endtask

  task automatic test_decode();
    drive(1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    tick();
    checks++;
    if (bus.out0 !== 4'hC || bus.out1 !== 4'hA || bus.out_valid !== 4'b0111) begin
      errors++;
      $display("FAIL decode_and got out0=%h out1=%h valid=%b want C A 0111", bus.out0, bus.out1, bus.out_valid);
    end
    drive(1'b1, 4'hD, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
    tick();
    checks++;
    if (bus.out3 !== 4'hD || bus.out_valid !== 4'b1111) begin
      errors++;
      $display("FAIL decode_or got out3=%h valid=%b want D 1111", bus.out3, bus.out_valid);
    end
  endtask

  task automatic test_clr_midflight();
    clr = 1'b1;
    drive(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
    tick();
    clr = 1'b0;
    checks++;
    if (bus.out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL clr_valid got %b want 0000", bus.out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut_out(k) !== '0) begin
        errors++;
        $display("FAIL clr_out%0d got %h want 0", k, dut_out(k));
      end
    end
    drive(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_after_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clr = ($urandom_range(0, 39) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = N'($urandom);
      bus.out_ready = 4'($urandom);
      drive_sel(int'($urandom_range(0, 3)));
      #1;
      checks++;
      if (bus.in_ready !== model_ready()) begin
        errors++;
        $display("FAIL rand_ready cycle %0d got %b want %b", c, bus.in_ready, model_ready());
      end
      tick();
      checks++;
      if (bus.out_valid !== model_valid()) begin
        errors++;
        $display("FAIL rand_valid cycle %0d got %b want %b", c, bus.out_valid, model_valid());
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dut_out(k) !== exp_out[k]) begin
          errors++;
          $display("FAIL rand_out%0d cycle %0d got %h want %h", k, c, dut_out(k), exp_out[k]);
        end
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.A1 = 1'b0; bus.B1 = 1'b0; bus.A0 = 1'b0; bus.B0 = 1'b0;
    bus.out_ready = 4'b0000;
    @(posedge clk);
    #1;
    test_reset();
    test_fill_stall();
    test_independence();
    test_back_to_back();
    test_decode();
    test_clr_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s2_route_demux.md
Name: s2_route_demux

Overview:
- Registered 1-to-4 demultiplexer, the inverse of the S2 4:1 registered-mux cell.
- One N-bit input stream is steered to one of four output lanes by the same select decode S2 uses: S1 = A1|B1, S0 = A0&B0.
- Each lane has a one-entry output register with valid/ready handshake, so the block can feed four downstream consumers that stall independently.
- Sits after an S2-built datapath stage that merges four sources; this block splits them back out.

Parameters:
N, 1, data width of input word and of each lane register.

Ports:
clk  input  1  rising-edge clock for all state.
clr  input  1  reset: synchronous, active-high, clears all state on the next clk edge.
in_data  input  N  word to route.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block accepts in_data this cycle; combinational.
A1  input  1  select term; S1 = A1|B1.
B1  input  1  select term; S1 = A1|B1.
A0  input  1  select term; S0 = A0&B0.
B0  input  1  select term; S0 = A0&B0.
out0  output  N  lane 0 register ({S1,S0}=00).
out1  output  N  lane 1 register ({S1,S0}=01).
out2  output  N  lane 2 register ({S1,S0}=10).
out3  output  N  lane 3 register ({S1,S0}=11).
out_valid  output  4  bit k set: outk holds an unconsumed word.
out_ready  input  4  bit k set: consumer k takes outk this cycle.

Behaviour:
- Reset: clk, synchronous, active-high clr. With clr=1 at a clk edge: out0..out3 <= 0, out_valid <= 4'b0000. Overrides any handshake that cycle. Mid-transfer clr discards buffered words; nothing is accepted that cycle even if in_ready was high.
- Select: sel = {A1|B1, A0&B0}, decoded combinationally each cycle. Must be stable while in_valid=1. Not registered.
- Lane k consume: out_valid[k] & out_ready[k].
- Lane k fill: in_valid & in_ready & (sel==k).
- in_ready = ~out_valid[sel] | out_ready[sel]. Ready depends only on the selected lane and ignores the other lanes' state. Never depends on in_valid.
- Per lane, at each clk edge with clr=0:
  - fill only: outk <= in_data, out_valid[k] <= 1.
  - consume only: out_valid[k] <= 0; outk holds its old value (data not cleared).
  - fill and consume in the same cycle: outk <= in_data, out_valid[k] stays 1. Full throughput, no bubble.
  - neither: hold.
- Latency: word accepted at edge t is visible on outk after edge t. One cycle, fixed.
- Independence: a stalled lane (out_valid=1, out_ready=0) blocks only inputs whose sel targets it. Other lanes keep draining.
- Consumers may assert out_ready while out_valid=0: no effect.
- Ordering: per-lane FIFO order of depth 1. No reordering possible.
- Width: no arithmetic. Data passes bit-exact at all N ≥ 1.

Test Plan:
- clr=1 for 2 cycles with in_valid=1, data 0x5 -> out0..3=0, out_valid=0000, and no word captured.
- N=4, A1=B1=0, A0=B0=1 (sel=01), in_data=0xA, in_valid=1, out_ready=0000 -> after 1 edge out1=0xA, out_valid=0010. Next cycle in_ready=0 with the same sel.
- Lane 1 full, A1=1, A0=0 (sel=10), in_data=0x3 -> in_ready=1. After the edge out2=0x3, out_valid=0110, and out1 is still 0xA.
- Lane 2 full, out_ready[2]=1, in_data=0x7 with sel=10 on every cycle for 4 cycles (0x7,0x8,0x9,0xB) -> in_ready stays 1. out2 shows each word one cycle later; out_valid[2] stays 1.
- A0=1, B0=0 (sel=00; S0 is AND so it decodes to 0, not 1), in_data=0xC -> out0=0xC and out1 is unchanged. Repeat with A0=B0=1, A1=0, B1=1 (sel=11), in_data=0xD -> out3=0xD.
- All lanes full, clr pulsed while in_valid=1 and out_ready=1111 -> after the edge out_valid=0000 and all outk=0. The following cycle in_ready=1.
